// File: rtl/operand_entry.sv
// Operand entry front-end for a signed 8-bit multiplier: two BCD digit editors (X, Y),
// sequential BCD-to-binary conversion with range check, and start/done handshake.
module operand_entry #(
  parameter int START_LEN = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        btnu_i,
  input  logic        btnd_i,
  input  logic        btnl_i,
  input  logic        btnr_i,
  input  logic        btnc_i,
  input  logic        done_i,
  output logic [7:0]  x_o,
  output logic [7:0]  y_o,
  output logic        start_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        sel_o,
  output logic [1:0]  cursor_o,
  output logic        neg_o,
  output logic [11:0] bcd_o
);

  typedef enum logic [2:0] {EDIT_X, CONV_X, EDIT_Y, CONV_Y, LAUNCH, BUSY} state_t;

  localparam logic [3:0] LAUNCH_LAST = 4'(START_LEN - 1);

  state_t      state_q, state_d;
  logic        x_sign, y_sign, x_hund, y_hund;
  logic [3:0]  x_tens, y_tens, x_ones, y_ones;
  logic [1:0]  cursor_q;
  logic        err_q;
  logic [1:0]  step_q;
  logic [8:0]  acc_q;
  logic [3:0]  launch_cnt_q;
  logic [7:0]  x_q, y_q;

  logic        show_y, edit, conv;
  logic        up_ok, dn_ok, lt_ok, rt_ok, accept, do_edit;
  logic        cur_sign, cur_hund;
  logic [3:0]  cur_tens, cur_ones;
  logic        nd_sign, nd_hund;
  logic [3:0]  nd_tens, nd_ones;
  logic [8:0]  acc_x10, acc_next, acc_neg;
  logic        legal;
  logic [7:0]  stored;

  assign show_y  = !(state_q == EDIT_X || state_q == CONV_X);
  assign edit    = (state_q == EDIT_X) || (state_q == EDIT_Y);
  assign conv    = (state_q == CONV_X) || (state_q == CONV_Y);

  // Opposing button pairs pressed together cancel each other out
  assign up_ok   = btnu_i & ~btnd_i;
  assign dn_ok   = btnd_i & ~btnu_i;
  assign lt_ok   = btnl_i & ~btnr_i;
  assign rt_ok   = btnr_i & ~btnl_i;
  assign accept  = edit & (btnc_i | up_ok | dn_ok | lt_ok | rt_ok);
  assign do_edit = edit & ~btnc_i;

  assign cur_sign = show_y ? y_sign : x_sign;
  assign cur_hund = show_y ? y_hund : x_hund;
  assign cur_tens = show_y ? y_tens : x_tens;
  assign cur_ones = show_y ? y_ones : x_ones;

  always_comb begin
    nd_sign = cur_sign;
    nd_hund = cur_hund;
    nd_tens = cur_tens;
    nd_ones = cur_ones;
    if (up_ok || dn_ok) begin
      case (cursor_q)
        2'd0: nd_ones = up_ok ? ((cur_ones >= 4'd9) ? 4'd0 : cur_ones + 4'd1)
                              : ((cur_ones == 4'd0) ? 4'd9 : cur_ones - 4'd1);
        2'd1: nd_tens = up_ok ? ((cur_tens >= 4'd9) ? 4'd0 : cur_tens + 4'd1)
                              : ((cur_tens == 4'd0) ? 4'd9 : cur_tens - 4'd1);
        2'd2: nd_hund = ~cur_hund;
        default: nd_sign = ~cur_sign;
      endcase
    end
  end

  // One digit folded into the accumulator per CONV cycle: H, then T, then O
  assign acc_x10 = acc_q * 9'd10;
  always_comb begin
    acc_next = {8'd0, cur_hund};
    if (step_q == 2'd1)      acc_next = acc_x10 + {5'd0, cur_tens};
    else if (step_q == 2'd2) acc_next = acc_x10 + {5'd0, cur_ones};
  end

  assign acc_neg = ~acc_next + 9'd1;
  assign legal   = cur_sign ? (acc_next <= 9'd128) : (acc_next <= 9'd127);
  assign stored  = cur_sign ? acc_neg[7:0] : acc_next[7:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      EDIT_X: if (btnc_i) state_d = CONV_X;
      EDIT_Y: if (btnc_i) state_d = CONV_Y;
      CONV_X: if (step_q == 2'd2) state_d = legal ? EDIT_Y : EDIT_X;
      CONV_Y: if (step_q == 2'd2) state_d = legal ? LAUNCH : EDIT_Y;
      LAUNCH: if (launch_cnt_q == LAUNCH_LAST) state_d = BUSY;
      BUSY:   if (done_i) state_d = EDIT_X;
      default: state_d = EDIT_X;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= EDIT_X;
      x_sign       <= 1'b0;
      x_hund       <= 1'b0;
      x_tens       <= 4'd0;
      x_ones       <= 4'd0;
      y_sign       <= 1'b0;
      y_hund       <= 1'b0;
      y_tens       <= 4'd0;
      y_ones       <= 4'd0;
      cursor_q     <= 2'd0;
      err_q        <= 1'b0;
      step_q       <= 2'd0;
      acc_q        <= 9'd0;
      launch_cnt_q <= 4'd0;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= 1'b0;
      if (do_edit) begin
        if (lt_ok) cursor_q <= cursor_q + 2'd1;
        if (rt_ok) cursor_q <= cursor_q - 2'd1;
        if (state_q == EDIT_Y) begin
          y_sign <= nd_sign;
          y_hund <= nd_hund;
          y_tens <= nd_tens;
          y_ones <= nd_ones;
        end else begin
          x_sign <= nd_sign;
          x_hund <= nd_hund;
          x_tens <= nd_tens;
          x_ones <= nd_ones;
        end
      end
      if (conv) begin
        acc_q  <= acc_next;
        step_q <= step_q + 2'd1;
        if (step_q == 2'd2) begin
          step_q <= 2'd0;
          if (legal) begin
            if (state_q == CONV_Y) y_q <= stored;
            else                   x_q <= stored;
            err_q    <= 1'b0;
            cursor_q <= 2'd0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
      if (state_q == LAUNCH)
        launch_cnt_q <= (launch_cnt_q == LAUNCH_LAST) ? 4'd0 : launch_cnt_q + 4'd1;
      if (state_q == BUSY && done_i) cursor_q <= 2'd0;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign start_o  = (state_q == LAUNCH);
  assign busy_o   = (state_q == BUSY);
  assign err_o    = err_q;
  assign sel_o    = show_y;
  assign cursor_o = cursor_q;
  assign neg_o    = cur_sign;
  assign bcd_o    = {3'd0, cur_hund, cur_tens, cur_ones};

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter START_LEN, default 1, width of the start_o pulse in clk_i cycles (legal 1..15).
REQ-002 clk_i  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset_i  in  1  reset, synchronous and active-high.
REQ-004 btnu_i, btnd_i  in  1 each  one-cycle pulses; increment / decrement the digit under the cursor.
REQ-005 btnl_i, btnr_i  in  1 each  one-cycle pulses; move the cursor left / right.
REQ-006 btnc_i  in  1  one-cycle pulse; commit the operand being edited.
REQ-007 done_i  in  1  multiplier completion level/pulse.
REQ-008 x_o, y_o  out  8 each  committed signed two's-complement operands.
REQ-009 start_o  out  1  multiplier start pulse.
REQ-010 busy_o  out  1  high while waiting for done_i.
REQ-011 err_o  out  1  last commit was out of range.
REQ-012 sel_o  out  1  operand being edited: 0 = X, 1 = Y.
REQ-013 cursor_o  out  2  digit position: 0 ones, 1 tens, 2 hundreds, 3 sign.
REQ-014 neg_o  out  1  sign digit of the edited operand: 1 = negative.
REQ-015 bcd_o  out  12  {hundreds, tens, ones} BCD of the edited operand.

Function
REQ-016 States: EDIT_X, CONV_X, EDIT_Y, CONV_Y, LAUNCH, BUSY.
REQ-017 X and Y each hold separate digit registers (sign, hundreds 0..1, tens 0..9, ones 0..9); bcd_o/neg_o show X in EDIT_X/CONV_X and Y otherwise.
REQ-018 In EDIT states: btnl_i does cursor+1 (3 wraps to 0); btnr_i does cursor-1 (0 wraps to 3).
REQ-019 In EDIT states: btnu_i increments the selected digit with wrap (ones/tens 9->0, hundreds 1->0, sign toggles); btnd_i decrements with wrap (0->9, 0->1, sign toggles).
REQ-020 Same-cycle btnu_i+btnd_i: both ignored; same-cycle btnl_i+btnr_i: both ignored.
REQ-021 btnc_i has priority: any edit in the commit cycle is discarded.
REQ-022 Commit in EDIT_X goes to CONV_X; commit in EDIT_Y goes to CONV_Y.
REQ-023 CONV is sequential over 3 cycles: acc=H; acc=acc*10+T; acc=acc*10+O (9-bit acc).
REQ-024 On the 3rd CONV cycle, range check: positive legal if acc<=127; negative legal if acc<=128.
REQ-025 A negative result is stored as two's complement (~acc+1)[7:0]; -0 is stored as 8'h00.
REQ-026 Legal: the operand register (x_o or y_o) updates on the 3rd rising edge after the commit edge; err_o=0; next state is EDIT_Y from CONV_X, or LAUNCH from CONV_Y; cursor resets to 0.
REQ-027 Illegal: x_o/y_o unchanged; err_o=1; return to the same EDIT state; digits and cursor retained.
REQ-028 err_o clears on the next accepted button pulse of any kind.
REQ-029 LAUNCH drives start_o=1 for START_LEN cycles, then moves to BUSY.
REQ-030 BUSY drives busy_o=1 and ignores all buttons; done_i=1 moves to EDIT_X with cursor 0; digit registers are retained.
REQ-031 done_i outside BUSY is ignored; buttons during CONV/LAUNCH are ignored.
REQ-032 sel_o=1 in EDIT_Y, CONV_Y, LAUNCH and BUSY; otherwise 0.

Reset
REQ-033 When reset_i=1 at a clock edge, from any state including mid-CONV/LAUNCH/BUSY, the next state is EDIT_X.
REQ-034 Reset values: x_o=y_o=0, all digits 0, sign positive, cursor_o=0, start_o=busy_o=err_o=sel_o=neg_o=0, bcd_o=0, CONV step counter 0, LAUNCH counter 0.
REQ-035 Reset takes priority over every button and over done_i in the same cycle.

Verification
REQ-036 Enter X=+127 (H=1,T=2,O=7), commit -> x_o=8'h7F exactly 3 edges later, sel_o=1, err_o=0.
REQ-037 Enter Y=-128, commit -> y_o=8'h80; start_o high for START_LEN cycles; busy_o=1 until done_i, then state EDIT_X, cursor_o=0.
REQ-038 Enter X=+128 or -129 (sign=1,1,2,9), commit -> err_o=1, x_o unchanged, still EDIT_X; next btnu_i clears err_o.
REQ-039 Wrap/conflict: ones=9 plus btnu_i -> 0; hundreds=0 plus btnd_i -> 1; cursor 3 plus btnl_i -> 0; btnu_i+btnd_i together -> no change; btnc_i+btnu_i together -> commit only.
REQ-040 -0 entered -> x_o=8'h00; buttons and done_i asserted during CONV_X -> no effect.
REQ-041 reset_i asserted in BUSY and in the 2nd CONV cycle -> all outputs at reset values on the following edge.
